// File: rtl/decoder_scan_n.sv
// Registered one-hot select generator: direct N-to-2^N decode or auto-scan
// through every line with a programmable per-line dwell and a wrap pulse.
module decoder_scan_n #(
  parameter  int unsigned SEL_W      = 3,
  parameter  int unsigned DWELL      = 4,
  parameter  bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W      = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             active,
  output logic             wrap
);

  localparam int unsigned      CNT_W      = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // XOR mask that turns a positive one-hot into the requested polarity.
  localparam logic [OUT_W-1:0] POL_MASK   = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               active_q, active_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // branches below leaves a value unassigned and infers a latch.
    state_d  = IDLE;
    idx_d    = idx_q;
    out_d    = POL_MASK;
    active_d = 1'b0;
    wrap_d   = 1'b0;
    cnt_d    = '0;

    if (en) begin
      active_d = 1'b1;
      if (!mode) begin
        state_d = DIRECT;
        idx_d   = sel;
      end else begin
        state_d = SCAN;
        if (state_q != SCAN) begin
          // Entry always reseeds; a previous scan position is never resumed.
          idx_d = sel;
        end else if (cnt_q == DWELL_LAST) begin
          idx_d  = idx_q + 1'b1;
          wrap_d = &idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      out_d = decode(idx_d) ^ POL_MASK;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      out_q    <= POL_MASK;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out    = out_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: three instances (default, DWELL=1,
// ACTIVE_LOW=1) share stimulus; each expected entry names the instance it checks.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;

  logic [7:0] out0, out1, out2;
  logic [2:0] idx0, idx1, idx2;
  logic       act0, act1, act2;
  logic       wrap0, wrap1, wrap2;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out0), .idx(idx0), .active(act0), .wrap(wrap0)
  );

  decoder_scan_n #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u_dw1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out1), .idx(idx1), .active(act1), .wrap(wrap1)
  );

  decoder_scan_n #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out2), .idx(idx2), .active(act2), .wrap(wrap2)
  );

  typedef struct {
    int         dut;
    logic [7:0] out;
    logic [2:0] idx;
    logic       active;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [7:0] a_out, input logic [2:0] a_idx,
                       input logic a_act, input logic a_wrap, input exp_t x);
    checks++;
    if (a_out !== x.out || a_idx !== x.idx || a_act !== x.active || a_wrap !== x.wrap) begin
      errors++;
      $display("FAIL %s: got out=%h idx=%0d active=%b wrap=%b, expected out=%h idx=%0d active=%b wrap=%b",
               name, a_out, a_idx, a_act, a_wrap, x.out, x.idx, x.active, x.wrap);
    end
  endtask

  // Drive one cycle of inputs and record what the selected instance must
  // show right after the following rising edge.
  task automatic cyc(input logic r, input logic e, input logic m, input logic [2:0] s,
                     input int d, input logic [7:0] o, input logic [2:0] i,
                     input logic a, input logic w, input string n);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    sel  = s;
    x.dut = d; x.out = o; x.idx = i; x.active = a; x.wrap = w; x.name = n;
    sb.push_back(x);
  endtask

  // Monitor: registered outputs are sampled 1 time unit after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.dut)
          0:       check(x.name, out0, idx0, act0, wrap0, x);
          1:       check(x.name, out1, idx1, act1, wrap1, x);
          default: check(x.name, out2, idx2, act2, wrap2, x);
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with scan requested.
    cyc(1, 1, 1, 3'd5, 0, 8'h00, 3'd0, 0, 0, "reset_c1");
    cyc(1, 1, 1, 3'd5, 0, 8'h00, 3'd0, 0, 0, "reset_c2");
    cyc(0, 1, 1, 3'd5, 0, 8'h20, 3'd5, 1, 0, "post_reset_seed");

    // Direct sweep, then disable: idx holds last value.
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 3'(i), 0, 8'h01 << i, 3'(i), 1, 0, "direct_sweep");
    cyc(0, 0, 0, 3'd3, 0, 8'h00, 3'd7, 0, 0, "direct_disable");

    // Scan seeded at 6; sel changes after entry must be ignored.
    cyc(0, 1, 1, 3'd6, 0, 8'h40, 3'd6, 1, 0, "scan_entry_no_wrap");
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 1, 3'd2, 0, 8'h40, 3'd6, 1, 0, "scan_line6");
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 1, 3'd2, 0, 8'h80, 3'd7, 1, 0, "scan_line7");
    cyc(0, 1, 1, 3'd2, 0, 8'h01, 3'd0, 1, 1, "scan_wrap_pulse");
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 1, 3'd2, 0, 8'h01, 3'd0, 1, 0, "scan_line0_after_wrap");
    cyc(0, 1, 1, 3'd2, 0, 8'h02, 3'd1, 1, 0, "scan_line1");

    // en pulse mid-dwell at idx=3, then reseed from sel=1.
    cyc(0, 0, 1, 3'd3, 0, 8'h00, 3'd1, 0, 0, "idle_before_seed3");
    cyc(0, 1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "seed3_c1");
    cyc(0, 1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "seed3_c2");
    cyc(0, 0, 1, 3'd1, 0, 8'h00, 3'd3, 0, 0, "en_drop_mid_scan");
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 1, 3'd1, 0, 8'h02, 3'd1, 1, 0, "reseed1_after_en");
    cyc(0, 1, 1, 3'd1, 0, 8'h04, 3'd2, 1, 0, "reseed1_advance");

    // Same with rst mid-dwell.
    cyc(0, 0, 1, 3'd3, 0, 8'h00, 3'd2, 0, 0, "idle_before_seed3b");
    cyc(0, 1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "seed3b_c1");
    cyc(0, 1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0, "seed3b_c2");
    cyc(1, 1, 1, 3'd3, 0, 8'h00, 3'd0, 0, 0, "rst_mid_scan");
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 1, 3'd1, 0, 8'h02, 3'd1, 1, 0, "reseed1_after_rst");
    cyc(0, 1, 1, 3'd1, 0, 8'h04, 3'd2, 1, 0, "reseed1_rst_advance");

    // Mode 1->0 mid-dwell goes direct; return to scan reseeds.
    cyc(0, 1, 0, 3'd5, 0, 8'h20, 3'd5, 1, 0, "mode_to_direct");
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 1, 3'd4, 0, 8'h10, 3'd4, 1, 0, "mode_back_reseed4");
    cyc(0, 1, 1, 3'd4, 0, 8'h20, 3'd5, 1, 0, "reseed4_advance");

    // DWELL=1 instance: seed 0, advance every cycle, wrap once per 8.
    cyc(1, 0, 0, 3'd0, 1, 8'h00, 3'd0, 0, 0, "dw1_reset");
    for (int k = 1; k <= 17; k++)
      cyc(0, 1, 1, 3'd0, 1, 8'h01 << ((k - 1) % 8), 3'((k - 1) % 8), 1,
          (k > 1) && ((k - 1) % 8 == 0), "dw1_rotate");

    // ACTIVE_LOW instance.
    cyc(1, 0, 0, 3'd0, 2, 8'hFF, 3'd0, 0, 0, "al_reset");
    cyc(0, 1, 0, 3'd2, 2, 8'hFB, 3'd2, 1, 0, "al_direct_sel2");
    cyc(0, 0, 0, 3'd2, 2, 8'hFF, 3'd2, 0, 0, "al_disable");

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. It adds an auto-scan mode that steps the active output through all 2^N lines with a programmable dwell per line. It serves as the common select generator for row/digit multiplexing (7-seg digit select, keypad row drive) and for memory/bank chip-select. Outputs are registered, so downstream select lines are glitch-free.

Parameters:
SEL_W, 3, width of the select index; OUT_W = 2**SEL_W (derived localparam, not overridable).
DWELL, 4, clock cycles each line stays active in scan mode; legal range 1..65535.
ACTIVE_LOW, 0, 1 inverts every bit of out (active line = 0, inactive = 1).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  enable; low forces all lines inactive.
mode  input  1  0 = direct decode, 1 = auto-scan.
sel  input  SEL_W  index to decode (direct) / seed index on scan entry.
out  output  OUT_W  registered one-hot select (polarity per ACTIVE_LOW).
idx  output  SEL_W  registered index currently driven on out.
active  output  1  high when out has a line asserted.
wrap  output  1  single-cycle pulse when scan rolls from OUT_W-1 to 0.

Behaviour:
- Reset, sampled on clk edge only: state=IDLE; out=all-inactive (0s, or 1s if ACTIVE_LOW); idx=0; active=0; wrap=0; dwell counter=0. Reset overrides all other inputs and takes effect mid-scan.
- States are IDLE, DIRECT and SCAN. Next state is evaluated every edge: en=0 goes to IDLE; en=1 with mode=0 goes to DIRECT; en=1 with mode=1 goes to SCAN.
- IDLE: out all-inactive, active=0, idx holds last value, dwell counter cleared, wrap=0.
- DIRECT: at each edge, idx<=sel and out<=onehot(sel); active=1. Latency is 1 cycle from sel/en/mode to out. The dwell counter is held at 0.
- SCAN entry from IDLE or DIRECT: idx<=sel (seed), out<=onehot(sel), dwell counter<=0. The first line therefore dwells exactly DWELL cycles.
- SCAN steady state: dwell counter increments each cycle. When it equals DWELL-1, the counter reloads 0 and idx<=idx+1. Otherwise idx holds. out tracks idx (onehot).
- Wrap-around: when idx advances from OUT_W-1, it becomes 0. wrap=1 for exactly the one cycle in which out first shows line 0. No pulse on entry even if the seed is 0.
- DWELL=1: idx advances every cycle, and wrap pulses once every OUT_W cycles.
- mode change 1->0 mid-dwell: the next cycle is DIRECT with the sel decode. Scan position is discarded, and re-entry reseeds from sel.
- sel changes during SCAN are ignored.
- en drop mid-scan: the next cycle is all-inactive. On en return, scan reseeds from sel and does not resume.
- Invariants: active=1 implies exactly one line asserted; active=0 implies none. out never shows a multi-hot or partial value.
- Dwell counter width is clog2(DWELL)+1 bits, with no overflow for any legal DWELL.

Test Plan:
(SEL_W=3, DWELL=4, ACTIVE_LOW=0 unless stated)
- Reset: assert rst 2 cycles with en=1, mode=1, sel=5 -> out=8'h00, idx=0, active=0, wrap=0. Check the 1st cycle after rst is released shows out=8'h20.
- Direct sweep: en=1, mode=0, sel=0..7 one per cycle -> out=8'h01,02,04,...,80, each 1 cycle after sel; active=1. Then en=0 -> out=8'h00 next cycle, idx holds 7.
- Scan with wrap: mode=1, sel=6 -> out=8'h40 for 4 cycles, 8'h80 for 4, then 8'h01 with wrap=1 for that one cycle only, then 8'h02. Confirm no wrap pulse on entry.
- DWELL=1, seed 0: full 8-cycle period, out rotates 01->80. wrap high exactly once per 8 cycles, on the 01 cycle after 80, and not in the first cycle.
- Mid-operation: in scan at idx=3, cycle 2 of dwell, pulse en=0 one cycle -> out=8'h00, then reseed from sel=1 gives 8'h02 for the full 4 cycles. Repeat with rst instead of en -> out=8'h00, idx=0.
- ACTIVE_LOW=1: direct sel=2 -> out=8'hFB; en=0 -> out=8'hFF, active=0.
